// File: rtl/alu.sv
// alu -- 8-bit registered arithmetic/logic unit with a fixed 1-cycle latency.
//
// Each rising edge with in_valid=1 captures one operation. The registered
// result and status flags hold when in_valid=0. out_valid is in_valid
// delayed by one cycle.
//
// Optional feature: define ALU_SHIFT_EN to implement opcodes 110 (SHL) and
// 111 (SHR). Without it, those opcodes return 0 and raise illegal_op.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   in_valid     operands/opcode valid this cycle
//   operand_a    first operand (unsigned)
//   operand_b    second operand (unsigned)
//   alu_opcode   operation select: ADD, SUB, AND, OR, XOR, DIV, SHL, SHR
//   result       registered result
//   out_valid    result/flags valid this cycle
//   carry        ADD carry-out / SUB borrow
//   zero         registered result == 0
//   div_by_zero  DIV with operand_b == 0
//   illegal_op   unsupported opcode sampled
module alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             carry,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpDiv = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;
    localparam logic [2:0] OpShr = 3'b111;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             dbz_d, dbz_q;
    logic             ill_d, ill_q;
    logic             zero_q;
    logic             valid_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    always_comb begin
        sum      = {1'b0, operand_a} + {1'b0, operand_b};
        // Top bit of the widened difference is the borrow (a < b).
        diff     = {1'b0, operand_a} - {1'b0, operand_b};
        result_d = '0;
        carry_d  = 1'b0;
        dbz_d    = 1'b0;
        ill_d    = 1'b0;
        case (alu_opcode)
            OpAdd: begin
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
            end
            OpSub: begin
                result_d = diff[WIDTH-1:0];
                carry_d  = diff[WIDTH];
            end
            OpAnd: result_d = operand_a & operand_b;
            OpOr:  result_d = operand_a | operand_b;
            OpXor: result_d = operand_a ^ operand_b;
            OpDiv: begin
                if (operand_b == '0) begin
                    result_d = '1;
                    dbz_d    = 1'b1;
                end else begin
                    result_d = operand_a / operand_b;
                end
            end
`ifdef ALU_SHIFT_EN
            OpShl: result_d = operand_a << operand_b[2:0];
            OpShr: result_d = operand_a >> operand_b[2:0];
`else
            OpShl, OpShr: ill_d = 1'b1;
`endif
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            valid_q <= in_valid;
            // Idle cycles keep the last result and flags visible.
            if (in_valid) begin
                result_q <= result_d;
                carry_q  <= carry_d;
                zero_q   <= (result_d == '0);
                dbz_q    <= dbz_d;
                ill_q    <= ill_d;
            end
        end
    end

    assign result      = result_q;
    assign out_valid   = valid_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [2:0] alu_opcode;
    logic [7:0] result;
    logic       out_valid;
    logic       carry;
    logic       zero;
    logic       div_by_zero;
    logic       illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    alu #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .alu_opcode  (alu_opcode),
        .result      (result),
        .out_valid   (out_valid),
        .carry       (carry),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       dz;
        logic       il;
    } vec_t;

    typedef struct {
        logic       v;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       dz;
        logic       il;
    } exp_t;

    vec_t vecs[$];
    exp_t m;  // reference model state

`ifdef ALU_SHIFT_EN
    localparam bit ShiftEn = 1'b1;
`else
    localparam bit ShiftEn = 1'b0;
`endif

    // Reference model: plain integer arithmetic from the opcode rules.
    function automatic exp_t model_op(int a, int b, int op);
        exp_t e;
        int   r;
        e.v = 1'b1; e.c = 1'b0; e.dz = 1'b0; e.il = 1'b0;
        r = 0;
        case (op)
            0: begin r = a + b; e.c = (r > 255); r = r % 256; end
            1: begin e.c = (a < b); r = (a - b + 256) % 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: if (b == 0) begin r = 255; e.dz = 1'b1; end else r = a / b;
            6: if (ShiftEn) r = (a * (1 << (b % 8))) % 256; else e.il = 1'b1;
            default: if (ShiftEn) r = a / (1 << (b % 8)); else e.il = 1'b1;
        endcase
        e.res = 8'(r);
        e.z   = (r == 0);
        return e;
    endfunction

    task automatic check(string name, exp_t e);
        n_checks++;
        if ({out_valid, result, carry, zero, div_by_zero, illegal_op} !==
            {e.v, e.res, e.c, e.z, e.dz, e.il}) begin
            n_fail++;
            $display("FAIL %s: got v=%b res=%h c=%b z=%b dz=%b il=%b, want v=%b res=%h c=%b z=%b dz=%b il=%b",
                     name, out_valid, result, carry, zero, div_by_zero, illegal_op,
                     e.v, e.res, e.c, e.z, e.dz, e.il);
        end
    endtask

    // Drive one cycle, advance the model, sample #1 after the edge.
    task automatic step(logic r, logic iv, logic [7:0] a, logic [7:0] b, logic [2:0] op);
        rst = r; in_valid = iv; operand_a = a; operand_b = b; alu_opcode = op;
        if (r) m = '{v: 1'b0, res: 8'h00, c: 1'b0, z: 1'b0, dz: 1'b0, il: 1'b0};
        else if (iv) m = model_op(int'(a), int'(b), int'(op));
        else m.v = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        rst = 1'b0; in_valid = 1'b0; operand_a = '0; operand_b = '0; alu_opcode = '0;
        #1;

        // Directed vectors with hand-computed expectations.
        vecs.push_back('{8'h0A, 8'h05, 3'b000, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h0A, 8'h05, 3'b001, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h0A, 8'h05, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h0A, 8'h05, 3'b011, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h0A, 8'h05, 3'b100, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h0A, 8'h05, 3'b101, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h0A, 8'h00, 3'b101, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{8'h00, 8'h01, 3'b001, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h05, 8'h05, 3'b001, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
`ifdef ALU_SHIFT_EN
        vecs.push_back('{8'h81, 8'h09, 3'b110, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 8'h09, 3'b111, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'h81, 8'h08, 3'b110, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0});
`else
        vecs.push_back('{8'h81, 8'h09, 3'b110, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'h81, 8'h09, 3'b111, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
`endif

        // Reset for two cycles with a live operation presented.
        step(1'b1, 1'b1, 8'hFF, 8'h01, 3'b000);
        check("reset_cycle1", '{v: 1'b0, res: 8'h00, c: 1'b0, z: 1'b0, dz: 1'b0, il: 1'b0});
        step(1'b1, 1'b1, 8'h00, 8'h01, 3'b001);
        check("reset_cycle2", '{v: 1'b0, res: 8'h00, c: 1'b0, z: 1'b0, dz: 1'b0, il: 1'b0});

        // Back-to-back table vectors.
        foreach (vecs[i]) begin
            step(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            e = '{v: 1'b1, res: vecs[i].res, c: vecs[i].c, z: vecs[i].z,
                  dz: vecs[i].dz, il: vecs[i].il};
            check($sformatf("vec%0d_op%0d", i, vecs[i].op), e);
        end

        // Valid 1,0,1: idle cycle drops out_valid but holds result and flags.
        step(1'b0, 1'b1, 8'hFF, 8'h01, 3'b000);
        check("toggle_valid1", '{v: 1'b1, res: 8'h00, c: 1'b1, z: 1'b1, dz: 1'b0, il: 1'b0});
        step(1'b0, 1'b0, 8'h0A, 8'h00, 3'b101);
        check("toggle_idle_hold", '{v: 1'b0, res: 8'h00, c: 1'b1, z: 1'b1, dz: 1'b0, il: 1'b0});
        step(1'b0, 1'b1, 8'h0A, 8'h00, 3'b101);
        check("toggle_valid2", '{v: 1'b1, res: 8'hFF, c: 1'b0, z: 1'b0, dz: 1'b1, il: 1'b0});
        step(1'b0, 1'b0, 8'h00, 8'h00, 3'b000);
        check("idle_hold_dbz", '{v: 1'b0, res: 8'hFF, c: 1'b0, z: 1'b0, dz: 1'b1, il: 1'b0});

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                 3'($urandom));
            check($sformatf("rand%0d", i), m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
